// File: rtl/relay_pkg.sv
// Shared types and constants for the relay bank: channel state encoding,
// transit counter width and the legal range for pull-in/drop-out times.
package relay_pkg;

  typedef enum logic [1:0] {
    RESTING = 2'b00,
    RISING  = 2'b01,
    ENGAGED = 2'b10,
    FALLING = 2'b11
  } relay_state_t;

  localparam int TRANSIT_W   = 4;
  localparam int TRANSIT_MIN = 1;
  localparam int TRANSIT_MAX = (1 << TRANSIT_W) - 1;

endpackage

// File: rtl/relay_channel.sv
// One relay: armature FSM with pull-in/drop-out timing, saturating actuation
// counter and break-before-make gating of POLES contacts.
module relay_channel
  import relay_pkg::*;
#(
  parameter int POLES    = 4,
  parameter int PULL_IN  = 3,
  parameter int DROP_OUT = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             coil,
  input  logic             clear_counts,
  input  logic [POLES-1:0] pole_in,
  output logic [POLES-1:0] out_hi,
  output logic [POLES-1:0] out_lo,
  output logic             settled,
  output logic [CNT_W-1:0] act_count
);

  // cnt holds the transit cycles still to go after the next edge, so the
  // throw closes on the PULL_IN-th (DROP_OUT-th) sampled edge.
  localparam logic [TRANSIT_W-1:0] RISE_LOAD = TRANSIT_W'((PULL_IN  > 1) ? PULL_IN  - 2 : 0);
  localparam logic [TRANSIT_W-1:0] FALL_LOAD = TRANSIT_W'((DROP_OUT > 1) ? DROP_OUT - 2 : 0);

  relay_state_t           state_q, state_d;
  logic [TRANSIT_W-1:0]   cnt_q, cnt_d;
  logic                   pull_done;
  logic                   rest, eng;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pull_done = 1'b0;
    case (state_q)
      RESTING, FALLING: begin
        if (coil) begin
          if (PULL_IN == 1) begin
            state_d   = ENGAGED;
            pull_done = 1'b1;
          end else begin
            state_d = RISING;
            cnt_d   = RISE_LOAD;
          end
        end else if (state_q == FALLING) begin
          if (cnt_q == '0) state_d = RESTING;
          else             cnt_d   = cnt_q - TRANSIT_W'(1);
        end
      end
      RISING, ENGAGED: begin
        if (!coil) begin
          if (DROP_OUT == 1) begin
            state_d = RESTING;
          end else begin
            state_d = FALLING;
            cnt_d   = FALL_LOAD;
          end
        end else if (state_q == RISING) begin
          if (cnt_q == '0) begin
            state_d   = ENGAGED;
            pull_done = 1'b1;
          end else begin
            cnt_d = cnt_q - TRANSIT_W'(1);
          end
        end
      end
      default: state_d = RESTING;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RESTING;
      cnt_q     <= '0;
      act_count <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (clear_counts)
        act_count <= '0;
      else if (pull_done && (act_count != '1))
        act_count <= act_count + CNT_W'(1);
    end
  end

  // A relay held in reset rests on its NC contacts even before the first edge.
  assign rest    = reset | (state_q == RESTING);
  assign eng     = ~reset & (state_q == ENGAGED);
  assign out_hi  = pole_in & {POLES{eng}};
  assign out_lo  = pole_in & {POLES{rest}};
  assign settled = rest | eng;

endmodule

// File: rtl/relay_bank.sv
// Bank of CHANNELS independent double-throw relays with cycle-accurate
// contact timing; contact path is purely combinational from pole_in.
module relay_bank
  import relay_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int POLES    = 4,
  parameter int PULL_IN  = 3,
  parameter int DROP_OUT = 2,
  parameter int CNT_W    = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [CHANNELS-1:0]                coil,
  input  logic                               clear_counts,
  input  logic [CHANNELS-1:0][POLES-1:0]     pole_in,
  output logic [CHANNELS-1:0][POLES-1:0]     out_hi,
  output logic [CHANNELS-1:0][POLES-1:0]     out_lo,
  output logic [CHANNELS-1:0]                settled,
  output logic [CHANNELS-1:0][CNT_W-1:0]     act_count
);

  if (PULL_IN < TRANSIT_MIN || PULL_IN > TRANSIT_MAX) begin : g_bad_pull_in
    $error("relay_bank: PULL_IN must be within 1..15");
  end
  if (DROP_OUT < TRANSIT_MIN || DROP_OUT > TRANSIT_MAX) begin : g_bad_drop_out
    $error("relay_bank: DROP_OUT must be within 1..15");
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    relay_channel #(
      .POLES   (POLES),
      .PULL_IN (PULL_IN),
      .DROP_OUT(DROP_OUT),
      .CNT_W   (CNT_W)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .coil        (coil[c]),
      .clear_counts(clear_counts),
      .pole_in     (pole_in[c]),
      .out_hi      (out_hi[c]),
      .out_lo      (out_lo[c]),
      .settled     (settled[c]),
      .act_count   (act_count[c])
    );
  end

endmodule
